// File: rtl/uart_rx_fifo.sv
// UART receiver for the picorv32 native bus: 2-flop input sync, 8N1 deframer,
// receive FIFO and a DATA/STATUS register pair.
module uart_rx_fifo #(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    input  logic        serialIn
);

    localparam int BIT_TICKS  = CLK_HZ / BAUD;
    localparam int HALF_TICKS = BIT_TICKS / 2;
    localparam int CNT_W      = (BIT_TICKS > 2) ? $clog2(BIT_TICKS) : 1;
    localparam int AW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(BIT_TICKS - 1);
    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(HALF_TICKS - 1);
    localparam logic [AW:0]      DEPTH_CNT   = (AW + 1)'(FIFO_DEPTH);

    // IDLE: wait start edge | START: mid-bit recheck | DATA: 8 bits LSB first | STOP: check stop | BREAK: wait line high
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } rx_state_t;

    logic             rx_meta;
    logic             rx;
    rx_state_t        state;
    rx_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [2:0]       idx;
    logic [2:0]       idx_nxt;
    logic [7:0]       shreg;
    logic [7:0]       shreg_nxt;
    logic             push;
    logic             frame_set;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_nxt;
    logic             overrun;
    logic             frame_err;

    logic             req;
    logic             is_write;
    logic [1:0]       reg_sel;
    logic             empty;
    logic             full;
    logic             pop;
    logic             accept;
    logic             overrun_set;
    logic             clr_overrun;
    logic             clr_frame_err;
    logic [7:0]       count_byte;
    logic [31:0]      status_word;
    logic [31:0]      rdata_nxt;
    logic             unused_bits;

    assign unused_bits = &{1'b0, mem_instr, mem_addr[31:4], mem_addr[1:0],
                           mem_wdata[31:4], mem_wdata[1:0]};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rx_meta <= 1'b1;
            rx      <= 1'b1;
        end else begin
            rx_meta <= serialIn;
            rx      <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            shreg <= shreg_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        shreg_nxt = shreg;
        push      = 1'b0;
        frame_set = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rx) begin
                    state_nxt = S_START;
                    cnt_nxt   = HALF_RELOAD;
                end
            end
            S_START: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else if (!rx) begin
                    state_nxt = S_DATA;
                    cnt_nxt   = BIT_RELOAD;
                    idx_nxt   = '0;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_DATA: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    shreg_nxt[idx] = rx;
                    cnt_nxt        = BIT_RELOAD;
                    if (idx == 3'd7) begin
                        state_nxt = S_STOP;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else if (rx) begin
                    push      = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    frame_set = 1'b1;
                    state_nxt = S_BREAK;
                end
            end
            S_BREAK: begin
                if (rx) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign req      = mem_valid & enable & ~mem_ready;
    assign is_write = |mem_wstrb;
    assign reg_sel  = mem_addr[3:2];
    assign empty    = (count == '0);
    assign full     = (count == DEPTH_CNT);
    assign pop      = req & ~is_write & (reg_sel == 2'd0) & ~empty;

    // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
    assign accept      = push & (~full | pop);
    assign overrun_set = push & full & ~pop;

    assign clr_overrun   = req & is_write & (reg_sel == 2'd1) & mem_wstrb[0] & mem_wdata[2];
    assign clr_frame_err = req & is_write & (reg_sel == 2'd1) & mem_wstrb[0] & mem_wdata[3];

    always_comb begin
        count_nxt = count;
        case ({accept, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            fifo_mem[wr_ptr] <= shreg;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count     <= count_nxt;
            overrun   <= overrun_set | (overrun & ~clr_overrun);
            frame_err <= frame_set | (frame_err & ~clr_frame_err);
        end
    end

    assign count_byte  = 8'(count);
    assign status_word = {16'h0000, count_byte, 4'h0, frame_err, overrun, full, ~empty};

    always_comb begin
        rdata_nxt = '0;
        if (!is_write) begin
            case (reg_sel)
                2'd0:    rdata_nxt = empty ? 32'h0 : {24'h0, fifo_mem[rd_ptr]};
                2'd1:    rdata_nxt = status_word;
                default: rdata_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_ready <= 1'b0;
            mem_rdata <= '0;
        end else begin
            mem_ready <= req;
            mem_rdata <= req ? rdata_nxt : 32'h0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based receiver model, per-cycle
// bus output compare, directed scenarios plus randomized traffic.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

    localparam int CLK_HZ = 1_600_000;
    localparam int BAUD   = 100_000;
    localparam int DEPTH  = 16;
    localparam int B      = CLK_HZ / BAUD;

    logic        clk = 1'b0;
    logic        resetn;
    logic        enable;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        serial_in;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0]  mq[$];
    bit          m_ovr;
    bit          m_ferr;

    int          ack_cyc = -1;
    bit          exp_rd_chk;
    logic [31:0] exp_rdata;

    uart_rx_fifo #(
        .CLK_HZ    (CLK_HZ),
        .BAUD      (BAUD),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .enable   (enable),
        .mem_valid(mem_valid),
        .mem_ready(mem_ready),
        .mem_instr(mem_instr),
        .mem_addr (mem_addr),
        .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .serialIn (serial_in)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] m_status();
        return {16'h0000, 8'(mq.size()), 4'h0, m_ferr, m_ovr,
                (mq.size() == DEPTH), (mq.size() != 0)};
    endfunction

    function automatic void model_push(input logic [7:0] d);
        if (mq.size() == DEPTH) m_ovr = 1'b1;
        else mq.push_back(d);
    endfunction

    // Outputs are checked every cycle: ack exactly one cycle after the request, data from the model.
    always @(negedge clk) begin
        if (resetn) begin
            checks++;
            if (mem_ready !== (cyc == ack_cyc)) begin
                failures++;
                $display("FAIL ready_timing cyc=%0d got=%b exp=%b", cyc, mem_ready, (cyc == ack_cyc));
            end
            if (mem_ready && (cyc == ack_cyc) && exp_rd_chk) begin
                checks++;
                if (mem_rdata !== exp_rdata) begin
                    failures++;
                    $display("FAIL rdata_model cyc=%0d got=0x%08h exp=0x%08h", cyc, mem_rdata, exp_rdata);
                end
            end else if (!mem_ready) begin
                checks++;
                if (mem_rdata !== 32'h0) begin
                    failures++;
                    $display("FAIL rdata_idle cyc=%0d got=0x%08h exp=0x00000000", cyc, mem_rdata);
                end
            end
        end
    end

    task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", name, got, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after a rising edge with mem_ready low again.
    task automatic bus_op(input logic [1:0] sel, input logic [3:0] wstrb, input logic [31:0] wdata,
                          input bit en, output logic [31:0] rdata);
        logic [31:0] a;
        int n;
        a = $urandom;
        a[3:2] = sel;
        mem_addr  = a;
        mem_wstrb = wstrb;
        mem_wdata = wdata;
        mem_instr = 1'($urandom_range(0, 1));
        enable    = en;
        mem_valid = 1'b1;
        if (en) begin
            exp_rd_chk = (wstrb == 4'h0);
            exp_rdata  = 32'h0;
            if (wstrb == 4'h0) begin
                if (sel == 2'd0) begin
                    if (mq.size() != 0) exp_rdata = {24'h0, mq.pop_front()};
                end else if (sel == 2'd1) begin
                    exp_rdata = m_status();
                end
            end else if (sel == 2'd1 && wstrb[0]) begin
                if (wdata[2]) m_ovr = 1'b0;
                if (wdata[3]) m_ferr = 1'b0;
            end
            ack_cyc = cyc + 1;
        end
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!mem_ready && n < 4);
        if (en) begin
            checks++;
            if (!mem_ready) begin
                failures++;
                $display("FAIL ack_timeout sel=%0d got=0 exp=1", sel);
            end
        end
        rdata     = mem_rdata;
        mem_valid = 1'b0;
        enable    = 1'b0;
        mem_wstrb = 4'h0;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] sel, output logic [31:0] d);
        bus_op(sel, 4'h0, 32'h0, 1'b1, d);
    endtask

    task automatic wr(input logic [1:0] sel, input logic [3:0] wstrb, input logic [31:0] wdata);
        logic [31:0] d;
        bus_op(sel, wstrb, wdata, 1'b1, d);
    endtask

    task automatic drive(input logic v, input int n);
        serial_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_stop);
        drive(1'b0, B);
        for (int i = 0; i < 8; i++) drive(d[i], B);
        if (!bad_stop) begin
            drive(1'b1, B);
            model_push(d);
        end else begin
            drive(1'b0, 3 * B);
            m_ferr = 1'b1;
            drive(1'b1, B);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        mq.delete();
        m_ovr   = 1'b0;
        m_ferr  = 1'b0;
        ack_cyc = -1;
        resetn  = 1'b1;
    endtask

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog got=running exp=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int nops;
        enable    = 1'b0;
        mem_valid = 1'b0;
        mem_instr = 1'b0;
        mem_addr  = 32'h0;
        mem_wstrb = 4'h0;
        mem_wdata = 32'h0;
        serial_in = 1'b1;
        exp_rd_chk = 1'b0;
        exp_rdata  = 32'h0;
        @(posedge clk);
        #1;
        do_reset();
        repeat (2) @(posedge clk);
        #1;

        rd(2'd1, d); check_lit("reset_status", d, 32'h0);
        rd(2'd0, d); check_lit("empty_data", d, 32'h0);
        rd(2'd1, d); check_lit("empty_pop_status", d, 32'h0);

        send_frame(8'h55, 1'b0);
        send_frame(8'hA3, 1'b0);
        rd(2'd1, d); check_lit("two_byte_status", d, 32'h0000_0201);
        rd(2'd0, d); check_lit("data_55", d, 32'h55);
        rd(2'd0, d); check_lit("data_a3", d, 32'hA3);
        rd(2'd1, d); check_lit("drained_status", d, 32'h0);

        for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b0);
        rd(2'd1, d); check_lit("overrun_status", d, 32'h0000_1007);
        for (int i = 0; i < 16; i++) begin
            rd(2'd0, d);
            check_lit("fill_order", d, 32'(i));
        end
        rd(2'd1, d); check_lit("after_fill_status", d, 32'h4);
        wr(2'd1, 4'h0, 32'h4);
        rd(2'd1, d); check_lit("w1c_no_strobe", d, 32'h4);
        wr(2'd1, 4'h1, 32'h4);
        rd(2'd1, d); check_lit("w1c_overrun", d, 32'h0);

        send_frame(8'($urandom), 1'b1);
        rd(2'd1, d); check_lit("frame_err_status", d, 32'h8);
        send_frame(8'h7E, 1'b0);
        rd(2'd1, d); check_lit("after_break_status", d, 32'h109);
        rd(2'd0, d); check_lit("data_7e", d, 32'h7E);
        wr(2'd1, 4'h1, 32'h4);
        rd(2'd1, d); check_lit("ferr_kept", d, 32'h8);
        wr(2'd1, 4'h1, 32'h8);
        rd(2'd1, d); check_lit("ferr_cleared", d, 32'h0);

        wr(2'd0, 4'hF, 32'hFF);
        wr(2'd2, 4'hF, 32'hFFFF_FFFF);
        rd(2'd2, d); check_lit("reg2_zero", d, 32'h0);
        rd(2'd3, d); check_lit("reg3_zero", d, 32'h0);

        drive(1'b0, (3 * B) / 10 + 1);
        drive(1'b1, 3 * B);
        rd(2'd1, d); check_lit("glitch_status", d, 32'h0);

        for (int i = 0; i < 16; i++) send_frame(8'(16 + i), 1'b0);
        rd(2'd1, d); check_lit("full_status", d, 32'h0000_1003);
        fork
            send_frame(8'hC5, 1'b0);
            begin
                // Aim the pop at the stop-bit sampling edge: sync (2) + start detect (1) + half bit + 9 bits.
                repeat (3 + B / 2 + 9 * B - 1) @(posedge clk);
                #1;
                rd(2'd0, d);
                check_lit("coincide_pop", d, 32'h10);
            end
        join
        rd(2'd1, d); check_lit("coincide_status", d, 32'h0000_1003);
        for (int i = 1; i < 16; i++) begin
            rd(2'd0, d);
            check_lit("coincide_order", d, 32'(16 + i));
        end
        rd(2'd0, d); check_lit("coincide_last", d, 32'hC5);

        drive(1'b0, 3 * B);
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        serial_in = 1'b1;
        do_reset();
        repeat (2) @(posedge clk);
        #1;
        rd(2'd1, d); check_lit("midframe_reset_status", d, 32'h0);
        send_frame(8'h3C, 1'b0);
        rd(2'd0, d); check_lit("post_reset_data", d, 32'h3C);

        repeat (30) begin
            send_frame(8'($urandom), ($urandom_range(0, 5) == 0));
            drive(1'b1, $urandom_range(0, B));
            nops = $urandom_range(0, 3);
            repeat (nops) begin
                bus_op(2'($urandom_range(0, 3)),
                       ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0,
                       $urandom,
                       ($urandom_range(0, 7) != 0),
                       d);
            end
        end
        for (int i = 0; i <= DEPTH; i++) rd(2'd0, d);
        rd(2'd1, d);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
